alm_soa_div: RTL

- Pipelined approximate logarithmic divider; the inverse-direction companion to the ALM_SOA multiplier, with Q = a / b computed as antilog(log2 a − log2 b).
- Same number system as the multiplier:
  - leading-one detection gives the characteristic k;
  - the fraction is truncated to n−M bits;
  - a set-one compensation is applied to the result fraction LSB.
- Valid/ready streaming on both sides. Sits beside the multiplier in the approximate-arithmetic library.

---
 rtl/alm_pkg.sv | 38 +++
 rtl/alm_log_enc.sv | 35 +++
 rtl/alm_soa_div.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/alm_pkg.sv
// -----------------------------------------------------------------------------
// alm_pkg
// Shared number-system definitions for the ALM_SOA approximate divider.
//   N   operand width (dividend and divisor)
//   M   low log-fraction bits truncated away
//   F   fractional bits carried in the quotient
//   FW  kept log-fraction width (N - M)
//   KW  characteristic width ($clog2(N))
//   QW  quotient width (N + F)
//   EW  signed exponent width after subtraction (covers -N .. N-1)
// Stage records:
//   log_rec_t  S1 -> S2 : characteristic, truncated fraction, zero flag
//   sub_rec_t  S2 -> S3 : signed exponent, mantissa {1,fr}, zero flags
// -----------------------------------------------------------------------------
package alm_pkg;

  localparam int N  = 16;
  localparam int M  = 11;
  localparam int F  = 8;
  localparam int FW = N - M;
  localparam int KW = $clog2(N);
  localparam int QW = N + F;
  localparam int EW = KW + 1;

  typedef struct packed {
    logic [KW-1:0] k;
    logic [FW-1:0] f;
    logic          zero;
  } log_rec_t;

  typedef struct packed {
    logic signed [EW-1:0] e;
    logic [FW:0]          m;
    logic                 za;
    logic                 zb;
  } sub_rec_t;

endpackage : alm_pkg

// File: rtl/alm_log_enc.sv
// -----------------------------------------------------------------------------
// alm_log_enc
// Combinational log encoder: leading-one detection plus truncated fraction.
//   x_i    operand (N bits, unsigned)
//   rec_o  {k = leading-one index, f = FW bits just below it, zero = x_i==0}
// Bits below the kept fraction are simply dropped (truncation); when the
// leading one sits lower than FW the fraction is zero-filled from the right.
// -----------------------------------------------------------------------------
module alm_log_enc
  import alm_pkg::*;
(
  input  logic [N-1:0] x_i,
  output log_rec_t     rec_o
);

  logic [KW-1:0] k;
  logic [N-1:0]  norm;

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    k = '0;
    for (int i = 0; i < N; i++) begin
      if (x_i[i]) k = i[KW-1:0];
    end
  end

  // Left-justify so the leading one lands on bit N-1; the fraction is then
  // the next FW bits down, with zeros shifted in for short operands.
  assign norm = x_i << (KW'(N - 1) - k);

  assign rec_o.k    = k;
  assign rec_o.f    = norm[N-2 -: FW];
  assign rec_o.zero = ~|x_i;

endmodule : alm_log_enc

// File: rtl/alm_soa_div.sv
// -----------------------------------------------------------------------------
// alm_soa_div
// Pipelined approximate logarithmic divider: quot ~= a / b * 2^F computed as
// antilog(log2 a - log2 b) with truncated log fractions and set-one
// compensation on the result fraction LSB.
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand pair valid          in_ready  block can accept
//   a, b       dividend / divisor (n bits, unsigned)
//   out_valid  result valid                out_ready downstream accepts
//   quot       unsigned fixed-point quotient, F fractional bits (n+F bits)
//   dz         divide-by-zero flag, qualified by out_valid
// Pipeline: operands are captured on acceptance, then S1 (log encode),
// S2 (subtract) and S3 (antilog, output register). A single enable freezes
// every stage while the output is held by backpressure, so results leave in
// order at up to one per cycle, 3 edges after the accepting edge.
// -----------------------------------------------------------------------------
module alm_soa_div
  import alm_pkg::*;
#(
  parameter int n = alm_pkg::N,
  parameter int F = alm_pkg::F
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [n+F-1:0] quot,
  output logic           dz
);

  // Shift arithmetic is done in a window wide enough to hold the mantissa
  // shifted by the largest exponent, so overflow can be detected, not lost.
  localparam int SW = 16;
  localparam int WW = QW + FW + 1;

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  logic en;
  logic v0_q, v1_q, v2_q, out_valid_q;

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;

  // ---------------------------------------------------------------------------
  // Stage 0: captured operands
  // ---------------------------------------------------------------------------
  logic [N-1:0] a_q, b_q;

  // ---------------------------------------------------------------------------
  // S1: log encode both operands
  // ---------------------------------------------------------------------------
  log_rec_t enc_a_d, enc_b_d;
  log_rec_t ra_q, rb_q;

  alm_log_enc u_enc_a (.x_i(a_q), .rec_o(enc_a_d));
  alm_log_enc u_enc_b (.x_i(b_q), .rec_o(enc_b_d));

  // ---------------------------------------------------------------------------
  // S2: log subtract
  // ---------------------------------------------------------------------------
  sub_rec_t     s2_d, s2_q;
  logic [FW:0]  fdiff;
  logic         borrow;

  always_comb begin
    fdiff  = {1'b0, ra_q.f} - {1'b0, rb_q.f};
    borrow = fdiff[FW];
    s2_d.e = $signed({1'b0, ra_q.k}) - $signed({1'b0, rb_q.k})
             - $signed({{(EW-1){1'b0}}, borrow});
    // Set-one compensation: the LSB of the result fraction is forced high to
    // re-centre the error of the truncated fractions.
    s2_d.m  = {1'b1, fdiff[FW-1:1], 1'b1};
    s2_d.za = ra_q.zero;
    s2_d.zb = rb_q.zero;
  end

  // ---------------------------------------------------------------------------
  // S3: antilog (shift mantissa by e + F - FW) and special cases
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0] s_amt;
  logic [SW-1:0]        rshift;
  logic [WW-1:0]        wide;
  logic [QW-1:0]        quot_d;
  logic                 dz_d;

  always_comb begin
    s_amt  = {{(SW-EW){s2_q.e[EW-1]}}, s2_q.e} + SW'(F - FW);
    rshift = -s_amt;
    wide   = '0;
    if (!s_amt[SW-1]) begin
      wide = {{(WW-FW-1){1'b0}}, s2_q.m} << s_amt;
    end else begin
      wide = {{(WW-FW-1){1'b0}}, s2_q.m} >> rshift;
    end

    dz_d = 1'b0;
    if (s2_q.zb) begin
      quot_d = '1;
      dz_d   = 1'b1;
    end else if (s2_q.za) begin
      quot_d = '0;
    end else if (|wide[WW-1:QW]) begin
      quot_d = '1;
    end else begin
      quot_d = wide[QW-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers. Data fields are only meaningful under their valid
  // bit, so only valids and the visible outputs are reset.
  // ---------------------------------------------------------------------------
  logic [QW-1:0] quot_q;
  logic          dz_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      dz_q        <= 1'b0;
    end else if (en) begin
      v0_q        <= in_valid;
      a_q         <= a;
      b_q         <= b;
      v1_q        <= v0_q;
      ra_q        <= enc_a_d;
      rb_q        <= enc_b_d;
      v2_q        <= v1_q;
      s2_q        <= s2_d;
      out_valid_q <= v2_q;
      quot_q      <= quot_d;
      dz_q        <= dz_d;
    end
  end

  assign quot = quot_q;
  assign dz   = dz_q;

endmodule : alm_soa_div
